// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one single-port word memory between an
// instruction-fetch port and a load/store data port.
module mem_arbiter #(
  parameter int ADDR_W = 7,
  parameter int DATA_W = 32
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              i_req,
  input  logic [31:0]       i_addr,
  output logic              i_gnt,
  output logic              i_rvalid,
  output logic [DATA_W-1:0] i_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [31:0]       d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  input  logic [3:0]        d_wmask,
  output logic              d_gnt,
  output logic              d_rvalid,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_err,
  output logic              mem_re,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic [3:0]        mem_wmask,
  input  logic [DATA_W-1:0] mem_rdata
);

  typedef enum logic {IDLE, RD_RESP} state_t;

  state_t state_reg, state_next;
  logic   last_d_reg, last_d_next;     // 1: data port was granted most recently
  logic   owner_d_reg, owner_d_next;   // owner of the pending read response
  logic   oor_reg, oor_next;           // pending response is an out-of-range load
  logic   d_err_reg, d_err_next;
  logic   startup_reg;                 // blocks grants in the cycle after reset

  logic d_oor;
  logic allow;
  logic pick_d;
  logic grant_i;
  logic grant_d;

  // Byte offset and wrapped fetch bits are intentionally ignored.
  logic unused_bits;
  assign unused_bits = ^{i_addr[31:ADDR_W+2], i_addr[1:0], d_addr[1:0]};

  assign d_oor   = |d_addr[31:ADDR_W+2];
  assign allow   = (state_reg == IDLE) && !reset && !startup_reg;
  assign pick_d  = d_req && (!i_req || !last_d_reg);
  assign grant_d = allow && pick_d;
  assign grant_i = allow && i_req && !pick_d;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_reg   <= IDLE;
      last_d_reg  <= 1'b0;
      owner_d_reg <= 1'b0;
      oor_reg     <= 1'b0;
      d_err_reg   <= 1'b0;
      startup_reg <= 1'b1;
    end else begin
      state_reg   <= state_next;
      last_d_reg  <= last_d_next;
      owner_d_reg <= owner_d_next;
      oor_reg     <= oor_next;
      d_err_reg   <= d_err_next;
      startup_reg <= 1'b0;
    end
  end

  always_comb begin
    state_next   = state_reg;
    last_d_next  = last_d_reg;
    owner_d_next = owner_d_reg;
    oor_next     = oor_reg;
    d_err_next   = 1'b0;
    i_gnt        = 1'b0;
    d_gnt        = 1'b0;
    i_rvalid     = 1'b0;
    d_rvalid     = 1'b0;
    i_rdata      = '0;
    d_rdata      = '0;
    mem_re       = 1'b0;
    mem_we       = 1'b0;
    mem_addr     = '0;
    mem_wdata    = '0;
    mem_wmask    = '0;

    case (state_reg)
      IDLE: begin
        if (grant_i) begin
          i_gnt        = 1'b1;
          last_d_next  = 1'b0;
          mem_re       = 1'b1;
          mem_addr     = i_addr[ADDR_W+1:2];
          state_next   = RD_RESP;
          owner_d_next = 1'b0;
          oor_next     = 1'b0;
        end else if (grant_d) begin
          d_gnt       = 1'b1;
          last_d_next = 1'b1;
          d_err_next  = d_oor;
          if (d_we) begin
            if (!d_oor) begin
              mem_we    = 1'b1;
              mem_addr  = d_addr[ADDR_W+1:2];
              mem_wdata = d_wdata;
              mem_wmask = d_wmask;
            end
          end else begin
            // Out-of-range loads still take the response slot so that the
            // requester sees a normal rvalid handshake carrying the error.
            state_next   = RD_RESP;
            owner_d_next = 1'b1;
            oor_next     = d_oor;
            if (!d_oor) begin
              mem_re   = 1'b1;
              mem_addr = d_addr[ADDR_W+1:2];
            end
          end
        end
      end
      RD_RESP: begin
        state_next = IDLE;
        if (!reset) begin
          if (owner_d_reg) begin
            d_rvalid = 1'b1;
            d_rdata  = oor_reg ? '0 : mem_rdata;
          end else begin
            i_rvalid = 1'b1;
            i_rdata  = mem_rdata;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign d_err = d_err_reg && !reset;

endmodule
